// File: rtl/apple_bus_drive_arbiter.sv
// rtl/apple_bus_drive_arbiter.sv - Apple II bus read-data drive arbiter with phased transceiver OE
module apple_bus_drive_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DRIVE_START = 4,
  parameter int HOLD_COUNT  = 2
) (
  input  logic                   clk_logic_i,
  input  logic                   system_reset_n_i,
  input  logic                   phi0_posedge_i,
  input  logic                   phi0_negedge_i,
  input  logic                   rw_n_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic [7:0]             a2_d_o,
  output logic                   a2_d_oe_n_o,
  output logic                   busy_o,
  output logic                   conflict_o,
  output logic [7:0]             conflict_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_DRIVE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [NUM_REQ-1:0]   r_grant;
  logic [7:0]           r_data;
  logic                 r_oe_n;
  logic                 r_busy;
  logic                 r_conflict;
  logic [7:0]           r_conflict_count;

  logic [NUM_REQ-1:0]   w_win_onehot;
  logic [7:0]           w_win_byte;
  logic                 w_seen;
  logic                 w_multi;
  logic                 w_start;

  // Scan high-to-low so the lowest set index ends up as the winner.
  always_comb begin
    w_win_onehot = '0;
    w_win_byte   = 8'h00;
    w_seen       = 1'b0;
    w_multi      = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        w_win_onehot    = '0;
        w_win_onehot[k] = 1'b1;
        w_win_byte      = req_data_i[8*k +: 8];
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_i[k]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
  end

  // A Phi0 rise re-arbitrates from IDLE and also pre-empts DRIVE/HOLD.
  assign w_start = phi0_posedge_i & rw_n_i & (|req_i) & (r_state != S_DELAY);

  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      r_state          <= S_IDLE;
      r_cnt            <= 4'd0;
      r_grant          <= '0;
      r_data           <= 8'h00;
      r_oe_n           <= 1'b1;
      r_busy           <= 1'b0;
      r_conflict       <= 1'b0;
      r_conflict_count <= 8'd0;
    end else begin
      r_conflict <= 1'b0;
      if (w_start) begin
        r_grant <= w_win_onehot;
        r_data  <= w_win_byte;
        r_busy  <= 1'b1;
        if (w_multi) begin
          r_conflict <= 1'b1;
          if (r_conflict_count != 8'hFF) r_conflict_count <= r_conflict_count + 8'd1;
        end
        // Delay count is preloaded so OE first reads low exactly DRIVE_START cycles after the strobe.
        if (DRIVE_START == 1) begin
          r_state <= S_DRIVE;
          r_oe_n  <= 1'b0;
        end else begin
          r_state <= S_DELAY;
          r_cnt   <= 4'(DRIVE_START - 2);
          r_oe_n  <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_oe_n <= 1'b1;
          end
          S_DELAY: begin
            if (phi0_negedge_i) begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_oe_n  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (r_cnt == 4'd0) begin
              r_state <= S_DRIVE;
              r_oe_n  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_DRIVE: begin
            if (phi0_posedge_i || (phi0_negedge_i && HOLD_COUNT == 0)) begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_oe_n  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (phi0_negedge_i) begin
              r_state <= S_HOLD;
              r_cnt   <= 4'(HOLD_COUNT - 1);
            end
          end
          S_HOLD: begin
            if (phi0_posedge_i || r_cnt == 4'd0) begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_oe_n  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_oe_n  <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign grant_o          = r_grant;
  assign a2_d_o           = r_data;
  assign a2_d_oe_n_o      = r_oe_n;
  assign busy_o           = r_busy;
  assign conflict_o       = r_conflict;
  assign conflict_count_o = r_conflict_count;

endmodule

// File: tb/tb_apple_bus_drive_arbiter.sv
// tb/tb_apple_bus_drive_arbiter.sv - self-checking bench for apple_bus_drive_arbiter
module tb_apple_bus_drive_arbiter;

  localparam int NR = 4;
  localparam int DS = 4;
  localparam int HC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pp, pn, rw;
  logic [3:0]  req;
  logic [31:0] rd;
  logic [3:0]  grant;
  logic [7:0]  dout;
  logic        oe_n, busy, conf;
  logic [7:0]  ccount;

  always #5 clk = ~clk;

  apple_bus_drive_arbiter #(.NUM_REQ(NR), .DRIVE_START(DS), .HOLD_COUNT(HC)) dut (
    .clk_logic_i      (clk),
    .system_reset_n_i (rst_n),
    .phi0_posedge_i   (pp),
    .phi0_negedge_i   (pn),
    .rw_n_i           (rw),
    .req_i            (req),
    .req_data_i       (rd),
    .grant_o          (grant),
    .a2_d_o           (dout),
    .a2_d_oe_n_o      (oe_n),
    .busy_o           (busy),
    .conflict_o       (conf),
    .conflict_count_o (ccount)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;

  // Timeline model: an owner, the cycle it won, and the cycle its phase ended.
  int         m_owner, m_t, m_n;
  logic [7:0] m_data, m_count;
  logic       m_conf;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_t = 0; m_n = -1;
    m_data = 8'h00; m_count = 8'd0; m_conf = 1'b0;
  endtask

  task automatic model_step();
    int  c;
    int  w;
    bit  in_delay;
    c        = cycle;
    in_delay = (m_owner >= 0) && (c < m_t + DS);
    m_conf   = 1'b0;
    if (pp && rw && req != 4'd0 && !in_delay) begin
      w = 0;
      for (int i = NR - 1; i >= 0; i--) if (req[i]) w = i;
      m_owner = w; m_t = c; m_n = -1;
      m_data  = rd[8*w +: 8];
      if ($countones(req) >= 2) begin
        m_conf = 1'b1;
        if (m_count != 8'd255) m_count = m_count + 8'd1;
      end
    end else if (m_owner >= 0) begin
      if (pp && !in_delay) m_owner = -1;
      else if (pn && in_delay) m_owner = -1;
      else if (m_n < 0 && pn) begin
        m_n = c;
        if (HC == 0) m_owner = -1;
      end else if (m_n >= 0 && c >= m_n + HC) m_owner = -1;
    end
  endtask

  function automatic logic [31:0] model_pack();
    logic [3:0] g;
    logic       o;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    o = !((m_owner >= 0) && (cycle >= m_t + DS));
    return 32'({g, o, m_data, (m_owner >= 0), m_conf, m_count});
  endfunction

  function automatic logic [31:0] dut_pack();
    return 32'({grant, oe_n, dout, busy, conf, ccount});
  endfunction

  task automatic cyc(input logic p, input logic n, input logic r, input logic [3:0] q, input logic [31:0] d);
    pp = p; pn = n; rw = r; req = q; rd = d;
    model_step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b1, 4'd0, 32'd0);
  endtask

  typedef struct {
    logic        p, n, r;
    logic [3:0]  q;
    logic [31:0] d;
    logic [3:0]  g;
    logic        oe;
    logic [7:0]  dat;
    logic        cf;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'b0100, 32'h00A5_0000, 4'b0100, 1'b1, 8'hA5, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 32'h0000_0000, 4'b0100, 1'b1, 8'hA5, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'b0010, 32'h0000_FF00, 4'b0100, 1'b1, 8'hA5, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 32'h0000_0000, 4'b0100, 1'b0, 8'hA5, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 32'h0000_0000, 4'b0100, 1'b0, 8'hA5, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 32'h0000_0000, 4'b0100, 1'b0, 8'hA5, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 8'hA5, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 32'h4433_2211, 4'b0000, 1'b1, 8'hA5, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 4'b1010, 32'h3300_1100, 4'b0010, 1'b1, 8'h11, 1'b1, 8'd1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 8'h11, 1'b0, 8'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 8'h11, 1'b0, 8'd1};

    pp = 0; pn = 0; rw = 1; req = 0; rd = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_state", 0, dut_pack(), 32'({4'd0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0}));

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].p, tbl[i].n, tbl[i].r, tbl[i].q, tbl[i].d);
      check("table", i, 32'({grant, oe_n, dout, conf, ccount}),
            32'({tbl[i].g, tbl[i].oe, tbl[i].dat, tbl[i].cf, tbl[i].cnt}));
    end

    // Full-length read: OE low T+4..T+28 with Phi0 fall at T+26.
    cyc(1'b1, 1'b0, 1'b1, 4'b0100, 32'h00A5_0000);
    for (int k = 1; k <= 29; k++) begin
      check("read_oe_n", k, 32'(oe_n), 32'(!(k >= 4 && k <= 28)));
      check("read_grant", k, 32'(grant), (k <= 28) ? 32'h4 : 32'h0);
      check("read_data_noconf", k, 32'({dout, conf}), 32'({8'hA5, 1'b0}));
      if (k < 29) cyc(1'b0, (k == 26), 1'b1, 4'd0, 32'd0);
    end

    // Contention saturation through repeated short phases.
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'b1010, 32'h3300_1100);
      if (i < 2) begin
        check("contend_first", i, 32'({grant, dout, conf}), 32'({4'b0010, 8'h11, 1'b1}));
        check("contend_count", i, 32'(ccount), 32'(i + 2));
      end
      cyc(1'b0, 1'b1, 1'b1, 4'd0, 32'd0);
      if (i == 0) check("abort_release", i, 32'({grant, oe_n, busy}), 32'({4'd0, 1'b1, 1'b0}));
      idle(1);
    end
    check("count_saturated", 0, 32'(ccount), 32'd255);

    // Asynchronous reset while driving.
    cyc(1'b1, 1'b0, 1'b1, 4'b0001, 32'h0000_00FF);
    idle(3);
    check("drive_before_reset", 0, 32'(oe_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, 32'({grant, oe_n, busy, ccount}), 32'({4'd0, 1'b1, 1'b0, 8'd0}));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc(1'b1, 1'b0, 1'b1, 4'b0001, 32'h0000_005A);
    check("post_reset_grant", 0, 32'({grant, dout}), 32'({4'b0001, 8'h5A}));
    idle(2);
    check("post_reset_oe_t3", 0, 32'(oe_n), 32'd1);
    idle(1);
    check("post_reset_oe_t4", 0, 32'(oe_n), 32'd0);

    // Missed negedge: new Phi0 rise while still driving.
    cyc(1'b1, 1'b0, 1'b1, 4'b1000, 32'h7E00_0000);
    check("missed_neg_t1", 0, 32'({grant, dout, oe_n}), 32'({4'b1000, 8'h7E, 1'b1}));
    idle(2);
    check("missed_neg_t3", 0, 32'(oe_n), 32'd1);
    idle(1);
    check("missed_neg_t4", 0, 32'(oe_n), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 4'd0, 32'd0);
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 5) != 0,
          4'($urandom), $urandom);
      check("random", i, dut_pack(), model_pack());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
